// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the MIPS IF stage: registered-read word array with a
// valid/ready fetch handshake, fault flagging, and a run-time program load mode.
module inst_mem_loadable #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter              INIT_FILE = "",
  parameter logic [31:0] NOP       = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_ready,
  output logic              inst_valid,
  output logic [31:0]       instruction,
  output logic              inst_fault,
  output logic [1:0]        fault_code,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {StRun, StLoad, StFlush} state_e;

  localparam logic [ADDR_W:0] CountMax = (ADDR_W + 1)'(DEPTH);

  state_e      state_q;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic [ADDR_W-1:0] fetch_idx;

  always_comb begin
    fetch_idx    = fetch_addr[ADDR_W+1:2];
    misaligned   = |fetch_addr[1:0];
    out_of_range = |(fetch_addr >> (ADDR_W + 2));
    // A rising load_en wins over a fetch in the same cycle.
    accept       = (state_q == StRun) && !load_en && fetch_req && (!inst_valid || fetch_ready);
  end

  // Array is deliberately outside the reset domain so programs survive a reset.
  always_ff @(posedge clk) begin
    if (state_q == StLoad && load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      inst_valid  <= 1'b0;
      instruction <= '0;
      inst_fault  <= 1'b0;
      fault_code  <= 2'b00;
      busy        <= 1'b0;
      load_count  <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_en) begin
            state_q    <= StLoad;
            busy       <= 1'b1;
            inst_valid <= 1'b0;
            load_count <= '0;
          end else if (accept) begin
            inst_valid <= 1'b1;
            if (misaligned) begin
              instruction <= NOP;
              inst_fault  <= 1'b1;
              fault_code  <= 2'b01;
            end else if (out_of_range) begin
              instruction <= NOP;
              inst_fault  <= 1'b1;
              fault_code  <= 2'b10;
            end else begin
              instruction <= mem[fetch_idx];
              inst_fault  <= 1'b0;
              fault_code  <= 2'b00;
            end
          end else if (fetch_ready) begin
            inst_valid <= 1'b0;
          end
        end
        StLoad: begin
          if (load_we && load_count != CountMax) begin
            load_count <= load_count + 1'b1;
          end
          if (!load_en) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          state_q <= StRun;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
